// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the 5-port mesh router: port indices, flit type
// codes, widths and the state encoding of the per-port packet arbiter.
// No ports (package).
// ---------------------------------------------------------------------------
package noc_pkg;

  // Input/output port indices of the router
  localparam int LOCAL = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int EAST  = 3;
  localparam int SOUTH = 4;

  localparam int FLIT_W    = 18;
  localparam int PORT_W    = 3;
  localparam int NUM_PORTS = 5;

  // Flit type lives in data bits [17:16]; SINGLE is both head and tail
  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick5.sv
// ---------------------------------------------------------------------------
// rr_pick5
// Combinational round-robin picker over five candidates. Scans upward from
// (ptr+1) mod 5 with wrap and returns the first asserted candidate.
// Ports:
//   cand_i  [4:0]  candidate vector (bit i = input i wants the port)
//   ptr_i   [2:0]  index of the last served input (5..7 treated as 4)
//   gnt_o   [4:0]  one-hot pick, zero when no candidate
//   idx_o   [2:0]  index of the pick, zero when no candidate
// ---------------------------------------------------------------------------
module rr_pick5
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] cand_i,
  input  logic [PORT_W-1:0]    ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PORT_W-1:0]    idx_o
);

  logic [3:0] base;
  logic [3:0] idx;
  logic       found;

  // Offsets 1..5 from the pointer visit every input exactly once, ending on
  // the pointer itself so the last winner is served again only if alone.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    idx   = '0;
    base  = (ptr_i > 3'd4) ? 4'd4 : {1'b0, ptr_i};
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = base + 4'(k);
      if (idx >= 4'd5) begin
        idx = idx - 4'd5;
      end
      if (!found && cand_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/port_packet_arbiter.sv
// ---------------------------------------------------------------------------
// port_packet_arbiter
// Per-output-port packet scheduler. Picks one of the five router inputs
// whose routed port equals PORT_ID (round-robin), then holds that grant for
// a whole packet until the tail flit is accepted downstream or the watchdog
// expires. The one-hot grant steers the port's flit mux and ack demux.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_port_<dir>              input <dir> presents a routing decision
//   rout_port_<dir> [2:0]       routed output port of input <dir>
//   req_out_<dir>               flit valid from input <dir>
//   flit_type_<dir> [1:0]       type of the current flit of input <dir>
//   ack_out_port                downstream accepts the flit on this port
//   grant_<dir>                 registered one-hot grant
//   grant_id [2:0]              index of the granted input, 0 when idle
//   busy                        packet lock held
//   timeout                     one-cycle pulse before a watchdog release
// ---------------------------------------------------------------------------
module port_packet_arbiter
  import noc_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_port_local,
  input  logic        req_port_west,
  input  logic        req_port_north,
  input  logic        req_port_east,
  input  logic        req_port_south,
  input  logic [2:0]  rout_port_local,
  input  logic [2:0]  rout_port_west,
  input  logic [2:0]  rout_port_north,
  input  logic [2:0]  rout_port_east,
  input  logic [2:0]  rout_port_south,
  input  logic        req_out_local,
  input  logic        req_out_west,
  input  logic        req_out_north,
  input  logic        req_out_east,
  input  logic        req_out_south,
  input  logic [1:0]  flit_type_local,
  input  logic [1:0]  flit_type_west,
  input  logic [1:0]  flit_type_north,
  input  logic [1:0]  flit_type_east,
  input  logic [1:0]  flit_type_south,
  input  logic        ack_out_port,
  output logic        grant_local,
  output logic        grant_west,
  output logic        grant_north,
  output logic        grant_east,
  output logic        grant_south,
  output logic [2:0]  grant_id,
  output logic        busy,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_MAX      = '1;

  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] req_out_vec;
  logic [PORT_W-1:0]    rout_arr  [NUM_PORTS];
  logic [1:0]           ftype_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PORT_W-1:0]    pick_idx;

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PORT_W-1:0]    gid_q, gid_d;
  logic [PORT_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]     wd_q, wd_d;

  logic                 xfer;
  logic                 is_tail;
  logic                 timeout_hit;

  assign req_vec[LOCAL]     = req_port_local;
  assign req_vec[WEST]      = req_port_west;
  assign req_vec[NORTH]     = req_port_north;
  assign req_vec[EAST]      = req_port_east;
  assign req_vec[SOUTH]     = req_port_south;
  assign req_out_vec[LOCAL] = req_out_local;
  assign req_out_vec[WEST]  = req_out_west;
  assign req_out_vec[NORTH] = req_out_north;
  assign req_out_vec[EAST]  = req_out_east;
  assign req_out_vec[SOUTH] = req_out_south;
  assign rout_arr[LOCAL]    = rout_port_local;
  assign rout_arr[WEST]     = rout_port_west;
  assign rout_arr[NORTH]    = rout_port_north;
  assign rout_arr[EAST]     = rout_port_east;
  assign rout_arr[SOUTH]    = rout_port_south;
  assign ftype_arr[LOCAL]   = flit_type_local;
  assign ftype_arr[WEST]    = flit_type_west;
  assign ftype_arr[NORTH]   = flit_type_north;
  assign ftype_arr[EAST]    = flit_type_east;
  assign ftype_arr[SOUTH]   = flit_type_south;

  // An input competes only when its routing decision targets this port;
  // codes 5..7 can never equal a valid PORT_ID.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand[i] = req_vec[i] && (rout_arr[i] == PORT_W'(PORT_ID));
    end
  end

  rr_pick5 u_pick (
    .cand_i (cand),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  // Only the granted input's valid/type matter while locked.
  assign xfer        = req_out_vec[gid_q] && ack_out_port;
  assign is_tail     = (ftype_arr[gid_q] == TAIL) || (ftype_arr[gid_q] == SINGLE);
  assign timeout_hit = (TIMEOUT != 0) && (wd_q == TIMEOUT_CNT);

  // Next-state logic: grant on any candidate in IDLE; while locked, release on
  // an accepted tail or an expired watchdog, moving the pointer to the
  // released input so it gets lowest priority next time.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|cand) begin
          grant_d = pick_gnt;
          gid_d   = pick_idx;
          wd_d    = '0;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (timeout_hit || (xfer && is_tail)) begin
          grant_d = '0;
          gid_d   = '0;
          ptr_d   = gid_q;
          wd_d    = '0;
          state_d = ARB_IDLE;
        end else if (xfer) begin
          wd_d = '0;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        gid_d   = '0;
        wd_d    = '0;
      end
    endcase
  end

  // State, grant, pointer and watchdog registers; pointer resets to SOUTH so
  // LOCAL wins the first full tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= PORT_W'(SOUTH);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  assign grant_local = grant_q[LOCAL];
  assign grant_west  = grant_q[WEST];
  assign grant_north = grant_q[NORTH];
  assign grant_east  = grant_q[EAST];
  assign grant_south = grant_q[SOUTH];
  assign grant_id    = gid_q;
  assign busy        = (state_q == ARB_LOCKED);
  assign timeout     = (state_q == ARB_LOCKED) && timeout_hit;

endmodule

// File: tb/tb_port_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_port_packet_arbiter
// Directed bench for the output-port arbiter serving the north port
// (PORT_ID=2). The grant order each step should produce is queued when the
// requests are driven and popped when the grant is observed.
// ---------------------------------------------------------------------------
module tb_port_packet_arbiter;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  reqPort;
  logic [4:0]  reqOut;
  logic [2:0]  routPort [5];
  logic [1:0]  flitType [5];
  logic        ack;

  logic        grantLocal, grantWest, grantNorth, grantEast, grantSouth;
  logic [2:0]  grantId;
  logic        busy;
  logic        timeoutPulse;
  logic [4:0]  grantVec;

  int          checks   = 0;
  int          failures = 0;
  int          expectedQ[$];

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  assign grantVec = {grantSouth, grantEast, grantNorth, grantWest, grantLocal};

  port_packet_arbiter #(
    .PORT_ID (2),
    .TIMEOUT (64),
    .CNT_W   (7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_port_local  (reqPort[0]),
    .req_port_west   (reqPort[1]),
    .req_port_north  (reqPort[2]),
    .req_port_east   (reqPort[3]),
    .req_port_south  (reqPort[4]),
    .rout_port_local (routPort[0]),
    .rout_port_west  (routPort[1]),
    .rout_port_north (routPort[2]),
    .rout_port_east  (routPort[3]),
    .rout_port_south (routPort[4]),
    .req_out_local   (reqOut[0]),
    .req_out_west    (reqOut[1]),
    .req_out_north   (reqOut[2]),
    .req_out_east    (reqOut[3]),
    .req_out_south   (reqOut[4]),
    .flit_type_local (flitType[0]),
    .flit_type_west  (flitType[1]),
    .flit_type_north (flitType[2]),
    .flit_type_east  (flitType[3]),
    .flit_type_south (flitType[4]),
    .ack_out_port    (ack),
    .grant_local     (grantLocal),
    .grant_west      (grantWest),
    .grant_north     (grantNorth),
    .grant_east      (grantEast),
    .grant_south     (grantSouth),
    .grant_id        (grantId),
    .busy            (busy),
    .timeout         (timeoutPulse)
  );

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic rq, input logic [2:0] rp,
                               input logic ro, input logic [1:0] ft);
    reqPort[idx]  = rq;
    routPort[idx] = rp;
    reqOut[idx]   = ro;
    flitType[idx] = ft;
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i, 1'b0, 3'd0, 1'b0, BODY);
    end
    ack = 1'b0;
  endtask

  // Pop the next expected winner and compare the whole grant picture.
  task automatic expectGrant(input string tag);
    int id;
    if (expectedQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=grant expected=empty scoreboard", tag);
    end else begin
      id = expectedQ.pop_front();
      checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      checkOutput({tag, ".id"}, 32'(grantId), 32'(id));
      checkOutput({tag, ".vec"}, 32'(grantVec), 32'd1 << id);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".vec"}, 32'(grantVec), 32'd0);
    checkOutput({tag, ".id"}, 32'(grantId), 32'd0);
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    #12;
    checkIdle("reset");
    checkOutput("reset.timeout", 32'(timeoutPulse), 32'd0);
    #1 rst = 1'b1;

    // All five inputs contend with SINGLE flits: round-robin from local,
    // with one idle cycle after every accepted single.
    $display("[TB] full contention round robin");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i, 1'b1, 3'd2, 1'b1, SINGLE);
    end
    ack = 1'b1;
    expectedQ.push_back(0);
    expectedQ.push_back(1);
    expectedQ.push_back(2);
    expectedQ.push_back(3);
    expectedQ.push_back(4);
    expectedQ.push_back(0);
    for (int n = 0; n < 6; n++) begin
      tick();
      expectGrant($sformatf("rr%0d", n));
      tick();
      checkIdle($sformatf("rr%0d.gap", n));
    end
    clearInputs();

    // West alone sends HEAD, BODY, TAIL.
    $display("[TB] single west packet");
    applyStimulus(1, 1'b1, 3'd2, 1'b0, BODY);
    expectedQ.push_back(1);
    tick();
    expectGrant("west");
    reqPort[1]  = 1'b0;
    reqOut[1]   = 1'b1;
    flitType[1] = HEAD;
    ack         = 1'b1;
    tick();
    checkOutput("west.head.id", 32'(grantId), 32'd1);
    flitType[1] = BODY;
    tick();
    checkOutput("west.body.busy", 32'(busy), 32'd1);
    flitType[1] = TAIL;
    tick();
    checkIdle("west.tail");
    clearInputs();

    // North holds the lock while east and south wait; east follows north.
    $display("[TB] lock held against new requests");
    applyStimulus(2, 1'b1, 3'd2, 1'b1, HEAD);
    ack = 1'b1;
    expectedQ.push_back(2);
    tick();
    expectGrant("north");
    tick();
    checkOutput("north.head.id", 32'(grantId), 32'd2);
    applyStimulus(3, 1'b1, 3'd2, 1'b1, SINGLE);
    applyStimulus(4, 1'b1, 3'd2, 1'b1, SINGLE);
    reqOut[2] = 1'b0;
    tick();
    checkOutput("north.stall.id", 32'(grantId), 32'd2);
    checkOutput("north.stall.vec", 32'(grantVec), 32'd4);
    reqOut[2]   = 1'b1;
    flitType[2] = BODY;
    tick();
    checkOutput("north.body.id", 32'(grantId), 32'd2);
    flitType[2] = TAIL;
    reqPort[2]  = 1'b0;
    tick();
    checkIdle("north.tail");
    expectedQ.push_back(3);
    tick();
    expectGrant("east.after.north");
    tick();
    checkIdle("east.single");
    clearInputs();

    // South stalls with no ack; watchdog forces release after 64 cycles.
    $display("[TB] watchdog release");
    applyStimulus(4, 1'b1, 3'd2, 1'b0, BODY);
    expectedQ.push_back(4);
    tick();
    expectGrant("south");
    reqPort[4] = 1'b0;
    reqOut[4]  = 1'b1;
    ack        = 1'b0;
    repeat (63) tick();
    checkOutput("wd63.busy", 32'(busy), 32'd1);
    checkOutput("wd63.timeout", 32'(timeoutPulse), 32'd0);
    checkOutput("wd63.id", 32'(grantId), 32'd4);
    tick();
    checkOutput("wd64.timeout", 32'(timeoutPulse), 32'd1);
    checkOutput("wd64.busy", 32'(busy), 32'd1);
    tick();
    checkIdle("wd.release");
    checkOutput("wd.release.timeout", 32'(timeoutPulse), 32'd0);
    clearInputs();

    // Requests for other ports never win; ack toggling in IDLE is ignored.
    $display("[TB] non-matching routes");
    applyStimulus(0, 1'b1, 3'd5, 1'b1, HEAD);
    applyStimulus(1, 1'b1, 3'd6, 1'b1, SINGLE);
    applyStimulus(2, 1'b1, 3'd7, 1'b1, SINGLE);
    applyStimulus(3, 1'b1, 3'd3, 1'b1, SINGLE);
    applyStimulus(4, 1'b1, 3'd1, 1'b1, HEAD);
    for (int n = 0; n < 8; n++) begin
      ack = n[0];
      tick();
      checkIdle($sformatf("nomatch%0d", n));
    end
    clearInputs();

    // Move the pointer to north, lock west, then reset mid-packet.
    $display("[TB] reset mid-packet");
    applyStimulus(2, 1'b1, 3'd2, 1'b1, SINGLE);
    ack = 1'b1;
    expectedQ.push_back(2);
    tick();
    expectGrant("pre.north");
    tick();
    checkIdle("pre.north.done");
    clearInputs();
    applyStimulus(1, 1'b1, 3'd2, 1'b1, HEAD);
    ack = 1'b1;
    expectedQ.push_back(1);
    tick();
    expectGrant("pre.west");
    tick();
    checkOutput("pre.west.head.busy", 32'(busy), 32'd1);
    #3 rst = 1'b0;
    #1;
    checkIdle("midreset");
    checkOutput("midreset.timeout", 32'(timeoutPulse), 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i, 1'b1, 3'd2, 1'b0, BODY);
    end
    ack = 1'b0;
    expectedQ.push_back(0);
    tick();
    expectGrant("post.reset.tie");
    clearInputs();

    checkOutput("scoreboard.empty", 32'(expectedQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
